// File: rtl/sequence_checker_pkg.sv
// Shared definitions for the 0-5-7-6-3-2 sequence: code constants, checker state
// encoding and the next-code / legality helpers.
package sequence_checker_pkg;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd5;
    localparam logic [2:0] S2 = 3'd7;
    localparam logic [2:0] S3 = 3'd6;
    localparam logic [2:0] S4 = 3'd3;
    localparam logic [2:0] S5 = 3'd2;

    localparam logic [2:0] ILLEGAL_A = 3'd1;
    localparam logic [2:0] ILLEGAL_B = 3'd4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Illegal codes fall through to S0 so a corrupted word always maps onto the sequence.
    function automatic logic [2:0] seq_next(input logic [2:0] code);
        case (code)
            S0:      seq_next = S1;
            S1:      seq_next = S2;
            S2:      seq_next = S3;
            S3:      seq_next = S4;
            S4:      seq_next = S5;
            S5:      seq_next = S0;
            default: seq_next = S0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] code);
        is_legal = (code != ILLEGAL_A) && (code != ILLEGAL_B);
    endfunction

endpackage

// File: rtl/sequence_checker_next_lut.sv
// seq_next_lut: combinational 3-bit next-code lookup, shared with the counter.
module seq_next_lut
    import sequence_checker_pkg::*;
(
    input  logic [2:0] code_i,
    output logic [2:0] next_o
);

    assign next_o = seq_next(code_i);

endmodule

// File: rtl/sequence_checker.sv
// Receive-side monitor for the 0-5-7-6-3-2 counter: hunts, locks, flags misses.
// Define SEQ_CHK_SATURATE_EN to make err_count saturate instead of wrapping.
module sequence_checker
    import sequence_checker_pkg::*;
#(
    parameter int LOCK_N = 2,
    parameter int LOSS_N = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       q_in,
    input  logic             valid_in,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [2:0]       expected,
    output logic [CNT_W-1:0] err_count
);

    localparam int MATCH_W = $clog2(LOCK_N + 1);
    localparam int MISS_W  = $clog2(LOSS_N + 1);
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_N);
    localparam logic [MISS_W-1:0]  LOSS_TGT = MISS_W'(LOSS_N);

    state_e             state_q, state_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d, match_inc;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d, miss_inc;
    logic [2:0]         exp_q, exp_d;
    logic               err_q, err_d, wrap_q, wrap_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d, err_cnt_inc;
    logic [2:0]         next_of_q, next_of_exp;

    seq_next_lut u_next_q   (.code_i(q_in),  .next_o(next_of_q));
    seq_next_lut u_next_exp (.code_i(exp_q), .next_o(next_of_exp));

    assign match_inc = match_cnt_q + MATCH_W'(1);
    assign miss_inc  = miss_cnt_q + MISS_W'(1);

`ifdef SEQ_CHK_SATURATE_EN
    assign err_cnt_inc = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
`else
    assign err_cnt_inc = err_cnt_q + CNT_W'(1);
`endif

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        exp_d       = exp_q;
        err_cnt_d   = err_cnt_q;
        err_d       = 1'b0;
        wrap_d      = 1'b0;
        if (valid_in) begin
            case (state_q)
                HUNT: begin
                    if (is_legal(q_in)) begin
                        exp_d       = next_of_q;
                        match_cnt_d = MATCH_W'(1);
                        miss_cnt_d  = '0;
                        state_d     = (LOCK_N == 1) ? LOCKED : SYNC;
                    end
                end
                SYNC: begin
                    if (q_in == exp_q) begin
                        match_cnt_d = match_inc;
                        exp_d       = next_of_q;
                        if (match_inc == LOCK_TGT) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else if (is_legal(q_in)) begin
                        exp_d       = next_of_q;
                        match_cnt_d = MATCH_W'(1);
                    end else begin
                        state_d     = HUNT;
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-wheel on our own expectation; bad data never reseeds it.
                    exp_d = next_of_exp;
                    if (q_in == exp_q) begin
                        miss_cnt_d = '0;
                        wrap_d     = (q_in == S5);
                    end else begin
                        err_d      = 1'b1;
                        err_cnt_d  = err_cnt_inc;
                        miss_cnt_d = miss_inc;
                        if (miss_inc == LOSS_TGT) begin
                            state_d     = HUNT;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            exp_q       <= '0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err       = err_q;
    assign wrap      = wrap_q;
    assign expected  = exp_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: directed scenarios plus randomized streams checked
// against a behavioural model; a second instance with CNT_W=2 covers counter overflow.
module tb_sequence_checker;

    localparam int LOCK_N = 2;
    localparam int LOSS_N = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] q_in = 3'd0;
    logic       valid_in = 1'b0;

    logic       locked, err, wrap, locked_n, err_n, wrap_n;
    logic [2:0] expected, expected_n;
    logic [7:0] err_count;
    logic [1:0] err_count_n;

    int n_vec = 0;
    int n_bad = 0;

    sequence_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .q_in(q_in), .valid_in(valid_in),
        .locked(locked), .err(err), .wrap(wrap),
        .expected(expected), .err_count(err_count)
    );

    sequence_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .CNT_W(2)) u_dut_narrow (
        .clk(clk), .rst(rst), .q_in(q_in), .valid_in(valid_in),
        .locked(locked_n), .err(err_n), .wrap(wrap_n),
        .expected(expected_n), .err_count(err_count_n)
    );

    always #5 clk = ~clk;

    // Reference model: the sequence as a ring, position found by search.
    int seq_ring [6] = '{0, 5, 7, 6, 3, 2};
    int m_mode;   // 0 hunting, 1 syncing, 2 locked
    int m_match, m_miss, m_exp, m_err, m_wrap, m_errs;

    function automatic int ring_pos(int c);
        for (int i = 0; i < 6; i++) if (seq_ring[i] == c) return i;
        return -1;
    endfunction

    function automatic int ring_next(int c);
        int p = ring_pos(c);
        return (p < 0) ? 0 : seq_ring[(p + 1) % 6];
    endfunction

    function automatic int cnt_model(int width);
        int top = (1 << width);
`ifdef SEQ_CHK_SATURATE_EN
        return (m_errs >= top) ? top - 1 : m_errs;
`else
        return m_errs % top;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_match = 0; m_miss = 0; m_exp = 0;
        m_err = 0; m_wrap = 0; m_errs = 0;
    endtask

    task automatic model_step(input int q, input bit v);
        m_err = 0;
        m_wrap = 0;
        if (!v) return;
        if (m_mode == 0) begin
            if (ring_pos(q) >= 0) begin
                m_exp = ring_next(q); m_match = 1; m_miss = 0;
                m_mode = (LOCK_N == 1) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (q == m_exp) begin
                m_match++; m_exp = ring_next(q);
                if (m_match >= LOCK_N) begin m_mode = 2; m_miss = 0; end
            end else if (ring_pos(q) >= 0) begin
                m_exp = ring_next(q); m_match = 1;
            end else begin
                m_mode = 0; m_match = 0;
            end
        end else begin
            if (q == m_exp) begin
                m_miss = 0; m_wrap = (q == 2);
            end else begin
                m_err = 1; m_errs++; m_miss++;
            end
            m_exp = ring_next(m_exp);
            if (m_miss >= LOSS_N) begin m_mode = 0; m_match = 0; m_miss = 0; end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".locked"},   int'(locked),      int'(m_mode == 2));
        check({ph, ".err"},      int'(err),         m_err);
        check({ph, ".wrap"},     int'(wrap),        m_wrap);
        check({ph, ".expected"}, int'(expected),    m_exp);
        check({ph, ".errcnt"},   int'(err_count),   cnt_model(8));
        check({ph, ".errcnt2"},  int'(err_count_n), cnt_model(2));
        check({ph, ".locked2"},  int'(locked_n),    int'(m_mode == 2));
    endtask

    task automatic cycle(input string ph, input logic [2:0] q, input logic v);
        @(negedge clk);
        q_in = q;
        valid_in = v;
        @(posedge clk);
        #1;
        model_step(int'(q), v);
        check_all(ph);
    endtask

    // Assert reset between edges and check outputs clear before any clock edge.
    task automatic async_reset(input string ph);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int src;
        logic [2:0] w;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Lock on 0,5 and run a full lap.
        cycle("t1", 3'd0, 1'b1);
        check("t1_sync_unlocked", int'(locked), 0);
        cycle("t1", 3'd5, 1'b1);
        check("t1_locked", int'(locked), 1);
        foreach (seq_ring[i]) if (i >= 2) cycle("t1", 3'(seq_ring[i]), 1'b1);
        check("t1_wrap", int'(wrap), 1);
        cycle("t1", 3'd0, 1'b1);

        // Single bad word in place of 6.
        cycle("t2", 3'd5, 1'b1);
        cycle("t2", 3'd7, 1'b1);
        cycle("t2", 3'd4, 1'b1);
        check("t2_err", int'(err), 1);
        check("t2_cnt", int'(err_count), 1);
        check("t2_exp", int'(expected), 3);
        cycle("t2", 3'd3, 1'b1);
        check("t2_still_locked", int'(locked), 1);

        // Two consecutive misses drop lock; a 0 then reseeds SYNC.
        cycle("t3", 3'd4, 1'b1);
        cycle("t3", 3'd1, 1'b1);
        check("t3_unlocked", int'(locked), 0);
        check("t3_cnt", int'(err_count), 3);
        cycle("t3", 3'd0, 1'b1);
        check("t3_reseed_exp", int'(expected), 5);

        // Illegal codes hold HUNT; valid gap holds everything.
        cycle("t4", 3'd1, 1'b1);
        cycle("t4", 3'd1, 1'b1);
        cycle("t4", 3'd4, 1'b1);
        cycle("t4", 3'd7, 1'b1);
        for (int i = 0; i < 3; i++) cycle("t4gap", 3'($urandom_range(0, 7)), 1'b0);
        check("t4_gap_exp", int'(expected), 6);
        cycle("t4", 3'd6, 1'b1);
        check("t4_locked", int'(locked), 1);

        // Five isolated errors on a fresh count: narrow counter overflow.
        async_reset("t5rst");
        cycle("t5", 3'd0, 1'b1);
        cycle("t5", 3'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle("t5", 3'd1, 1'b1);
            cycle("t5", 3'(m_exp), 1'b1);
        end
`ifdef SEQ_CHK_SATURATE_EN
        check("t5_narrow_cnt", int'(err_count_n), 3);
`else
        check("t5_narrow_cnt", int'(err_count_n), 1);
`endif
        check("t5_wide_cnt", int'(err_count), 5);

        // Async reset while locked with an err pulse pending.
        cycle("t6", 3'd1, 1'b1);
        check("t6_err_before", int'(err), 1);
        async_reset("t6rst");
        check("t6_locked", int'(locked), 0);
        check("t6_exp", int'(expected), 0);

        // Randomized stream: mostly in sequence, with corruption, gaps and slips.
        src = 0;
        for (int n = 0; n < 600; n++) begin
            logic v;
            v = ($urandom_range(0, 9) != 0);
            if (v) begin
                if ($urandom_range(0, 49) == 0) src = seq_ring[$urandom_range(0, 5)];
                src = ring_next(src);
                w = ($urandom_range(0, 99) < 85) ? 3'(src) : 3'($urandom_range(0, 7));
            end else begin
                w = 3'($urandom_range(0, 7));
            end
            cycle("rnd", w, v);
            if (n == 300) async_reset("rndrst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
